// File: rtl/intr_pkg.sv
// intr_pkg: shared encodings for the interrupt sequencer.
//   state_t       - sequencer phases (idle, three stack pushes, four vector fetches)
//   vec_kind_t    - interrupt source being serviced
//   *_VEC_LO/HI   - low byte of each vector address
//   SEL_*         - bit positions of the one-hot bus preset select vector
//   preset_onehot - bus preset select for a given phase and source
package intr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_P,
    ST_VLO_ADH,
    ST_VLO_ADL,
    ST_VHI_ADH,
    ST_VHI_ADL
  } state_t;

  typedef enum logic [1:0] {
    VK_RESET,
    VK_NMI,
    VK_IRQ,
    VK_BRK
  } vec_kind_t;

  localparam logic [7:0] STACK_PAGE   = 8'h01;
  localparam logic [7:0] VECTOR_PAGE  = 8'hFF;
  localparam logic [7:0] RESET_VEC_LO = 8'hFC;
  localparam logic [7:0] RESET_VEC_HI = 8'hFD;
  localparam logic [7:0] NMI_VEC_LO   = 8'hFA;
  localparam logic [7:0] NMI_VEC_HI   = 8'hFB;
  localparam logic [7:0] IRQ_VEC_LO   = 8'hFE;
  localparam logic [7:0] IRQ_VEC_HI   = 8'hFF;

  localparam logic [1:0] PUSH_SEL_PCH = 2'd0;
  localparam logic [1:0] PUSH_SEL_PCL = 2'd1;
  localparam logic [1:0] PUSH_SEL_P   = 2'd2;

  // Bit positions inside the 8-bit preset select vector.
  localparam int SEL_01 = 0;
  localparam int SEL_00 = 1;
  localparam int SEL_FA = 2;
  localparam int SEL_FB = 3;
  localparam int SEL_FC = 4;
  localparam int SEL_FD = 5;
  localparam int SEL_FE = 6;
  localparam int SEL_FF = 7;

  // Resolve the preset byte for a phase, then turn it into a one-hot select.
  // IDLE drives no preset at all.
  function automatic logic [7:0] preset_onehot(input state_t s, input vec_kind_t k);
    logic [7:0] pbyte;
    logic       en;
    logic [7:0] oh;
    pbyte = VECTOR_PAGE;
    en    = 1'b1;
    oh    = '0;
    case (s)
      ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_P: pbyte = STACK_PAGE;
      ST_VLO_ADH, ST_VHI_ADH:              pbyte = VECTOR_PAGE;
      ST_VLO_ADL: pbyte = (k == VK_RESET) ? RESET_VEC_LO :
                          (k == VK_NMI)   ? NMI_VEC_LO : IRQ_VEC_LO;
      ST_VHI_ADL: pbyte = (k == VK_RESET) ? RESET_VEC_HI :
                          (k == VK_NMI)   ? NMI_VEC_HI : IRQ_VEC_HI;
      default:    en = 1'b0;
    endcase
    if (en) begin
      case (pbyte)
        8'h01:   oh[SEL_01] = 1'b1;
        8'h00:   oh[SEL_00] = 1'b1;
        8'hFA:   oh[SEL_FA] = 1'b1;
        8'hFB:   oh[SEL_FB] = 1'b1;
        8'hFC:   oh[SEL_FC] = 1'b1;
        8'hFD:   oh[SEL_FD] = 1'b1;
        8'hFE:   oh[SEL_FE] = 1'b1;
        8'hFF:   oh[SEL_FF] = 1'b1;
        default: oh = '0;
      endcase
    end
    return oh;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// nmi_edge_detect: latches a rising edge of the NMI line until the sequencer
// accepts it.
//   clk, rst - clock, synchronous active-high reset
//   nmi_in   - synchronised NMI line
//   clear    - sequencer has consumed the pending NMI
//   pending  - an NMI edge is waiting to be serviced
module nmi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic nmi_in,
  input  logic clear,
  output logic pending
);

  logic r_nmi_prev;
  logic r_nmi_pending;

  // The previous-level register runs every clock so edges are never missed
  // while the bus is stalled. A fresh edge beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nmi_prev    <= 1'b0;
      r_nmi_pending <= 1'b0;
    end else begin
      r_nmi_prev <= nmi_in;
      if (nmi_in && !r_nmi_prev)
        r_nmi_pending <= 1'b1;
      else if (clear)
        r_nmi_pending <= 1'b0;
    end
  end

  assign pending = r_nmi_pending;

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: arbitrates reset/NMI/BRK/IRQ and walks the stack-push
// and vector-fetch phases, driving one bus preset select per phase.
//   clk, rst           - clock, synchronous active-high reset
//   ready              - bus may advance; low holds all state and outputs
//   nmi_in, irq_in     - interrupt lines (NMI edge, IRQ level)
//   brk_req, i_flag    - BRK executed by decoder; processor I flag (masks IRQ)
//   set_FF..set_01     - one-hot bus preset selects
//   push_we, push_sel  - stack write strobe and byte select (PCH/PCL/P)
//   b_flag             - B bit for the pushed P
//   vec_kind           - source being serviced
//   busy, set_i, done  - sequence active; one-cycle completion pulses
module interrupt_sequencer
  import intr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic       nmi_in,
  input  logic       irq_in,
  input  logic       brk_req,
  input  logic       i_flag,
  output logic       set_FF,
  output logic       set_FE,
  output logic       set_FD,
  output logic       set_FC,
  output logic       set_FB,
  output logic       set_FA,
  output logic       set_00,
  output logic       set_01,
  output logic       push_we,
  output logic [1:0] push_sel,
  output logic       b_flag,
  output logic [1:0] vec_kind,
  output logic       busy,
  output logic       set_i,
  output logic       done
);

  state_t     r_state;
  vec_kind_t  r_vec_kind;
  logic       r_reset_pending;
  logic [7:0] r_sel;
  logic       r_push_we;
  logic [1:0] r_push_sel;
  logic       r_b_flag;
  logic       r_busy;
  logic       r_done;
  logic       r_set_i;

  logic       w_nmi_pending;
  logic       w_nmi_clear;
  logic       w_reset_clear;
  logic       w_finish;
  state_t     w_state_next;
  vec_kind_t  w_kind_next;
  logic [7:0] w_sel_next;
  logic       w_push_we_next;
  logic [1:0] w_push_sel_next;
  logic       w_b_flag_next;

  nmi_edge_detect u_nmi_edge_detect (
    .clk     (clk),
    .rst     (rst),
    .nmi_in  (nmi_in),
    .clear   (w_nmi_clear),
    .pending (w_nmi_pending)
  );

  always_comb begin
    w_state_next  = r_state;
    w_kind_next   = r_vec_kind;
    w_nmi_clear   = 1'b0;
    w_reset_clear = 1'b0;
    w_finish      = 1'b0;
    if (ready) begin
      case (r_state)
        ST_IDLE: begin
          if (r_reset_pending) begin
            // Reset has no return context, so it skips the pushes.
            w_state_next  = ST_VLO_ADH;
            w_kind_next   = VK_RESET;
            w_reset_clear = 1'b1;
          end else if (w_nmi_pending) begin
            w_state_next = ST_PUSH_PCH;
            w_kind_next  = VK_NMI;
            w_nmi_clear  = 1'b1;
          end else if (brk_req) begin
            w_state_next = ST_PUSH_PCH;
            w_kind_next  = VK_BRK;
          end else if (irq_in && !i_flag) begin
            w_state_next = ST_PUSH_PCH;
            w_kind_next  = VK_IRQ;
          end
        end
        ST_PUSH_PCH: w_state_next = ST_PUSH_PCL;
        ST_PUSH_PCL: w_state_next = ST_PUSH_P;
        ST_PUSH_P: begin
          w_state_next = ST_VLO_ADH;
          // A late NMI steals the vector of an IRQ/BRK whose context is
          // already on the stack; the pushed B bit stays as it was.
          if ((r_vec_kind == VK_IRQ || r_vec_kind == VK_BRK) && w_nmi_pending) begin
            w_kind_next = VK_NMI;
            w_nmi_clear = 1'b1;
          end
        end
        ST_VLO_ADH: w_state_next = ST_VLO_ADL;
        ST_VLO_ADL: w_state_next = ST_VHI_ADH;
        ST_VHI_ADH: w_state_next = ST_VHI_ADL;
        ST_VHI_ADL: begin
          w_state_next = ST_IDLE;
          w_finish     = 1'b1;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered with it, so they
  // are a clean Moore function of the visible state and hold while ready=0.
  always_comb begin
    w_sel_next      = preset_onehot(w_state_next, w_kind_next);
    w_push_we_next  = 1'b0;
    w_push_sel_next = PUSH_SEL_PCH;
    w_b_flag_next   = 1'b0;
    case (w_state_next)
      ST_PUSH_PCH: w_push_we_next = 1'b1;
      ST_PUSH_PCL: begin
        w_push_we_next  = 1'b1;
        w_push_sel_next = PUSH_SEL_PCL;
      end
      ST_PUSH_P: begin
        w_push_we_next  = 1'b1;
        w_push_sel_next = PUSH_SEL_P;
        w_b_flag_next   = (w_kind_next == VK_BRK);
      end
      default: w_push_we_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_vec_kind      <= VK_RESET;
      r_reset_pending <= 1'b1;
      r_sel           <= '0;
      r_push_we       <= 1'b0;
      r_push_sel      <= PUSH_SEL_PCH;
      r_b_flag        <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_set_i         <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_vec_kind <= w_kind_next;
      if (w_reset_clear)
        r_reset_pending <= 1'b0;
      r_sel      <= w_sel_next;
      r_push_we  <= w_push_we_next;
      r_push_sel <= w_push_sel_next;
      r_b_flag   <= w_b_flag_next;
      r_busy     <= (w_state_next != ST_IDLE);
      // Completion pulses last exactly one clock even if ready drops.
      r_done     <= w_finish;
      r_set_i    <= w_finish;
    end
  end

  assign set_FF   = r_sel[SEL_FF];
  assign set_FE   = r_sel[SEL_FE];
  assign set_FD   = r_sel[SEL_FD];
  assign set_FC   = r_sel[SEL_FC];
  assign set_FB   = r_sel[SEL_FB];
  assign set_FA   = r_sel[SEL_FA];
  assign set_00   = r_sel[SEL_00];
  assign set_01   = r_sel[SEL_01];
  assign push_we  = r_push_we;
  assign push_sel = r_push_sel;
  assign b_flag   = r_b_flag;
  assign vec_kind = r_vec_kind;
  assign busy     = r_busy;
  assign set_i    = r_set_i;
  assign done     = r_done;

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

  logic       clk = 1'b0;
  logic       rst, ready, nmi_in, irq_in, brk_req, i_flag;
  logic       set_FF, set_FE, set_FD, set_FC, set_FB, set_FA, set_00, set_01;
  logic       push_we, b_flag, busy, set_i, done;
  logic [1:0] push_sel, vec_kind;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position within the phase list of the active sequence.
  int   m_step;      // 0 = idle, 1..m_len = phase index within the sequence
  int   m_len;       // 4 for reset, 7 for the others
  int   m_kind;      // 0 RESET, 1 NMI, 2 IRQ, 3 BRK
  bit   m_rpend, m_npend, m_prev, m_done;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .ready(ready), .nmi_in(nmi_in), .irq_in(irq_in),
    .brk_req(brk_req), .i_flag(i_flag),
    .set_FF(set_FF), .set_FE(set_FE), .set_FD(set_FD), .set_FC(set_FC),
    .set_FB(set_FB), .set_FA(set_FA), .set_00(set_00), .set_01(set_01),
    .push_we(push_we), .push_sel(push_sel), .b_flag(b_flag),
    .vec_kind(vec_kind), .busy(busy), .set_i(set_i), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_update();
    bit rise, clr, fin;
    rise = nmi_in && !m_prev;
    clr  = 1'b0;
    fin  = 1'b0;
    if (rst) begin
      m_step = 0; m_len = 7; m_kind = 0;
      m_rpend = 1; m_npend = 0; m_prev = 0; m_done = 0;
    end else begin
      m_prev = nmi_in;
      if (ready) begin
        if (m_step == 0) begin
          if (m_rpend) begin
            m_kind = 0; m_len = 4; m_step = 1; m_rpend = 0;
          end else if (m_npend) begin
            m_kind = 1; m_len = 7; m_step = 1; clr = 1;
          end else if (brk_req) begin
            m_kind = 3; m_len = 7; m_step = 1;
          end else if (irq_in && !i_flag) begin
            m_kind = 2; m_len = 7; m_step = 1;
          end
        end else if (m_step == m_len) begin
          m_step = 0;
          fin    = 1;
        end else begin
          if (m_len == 7 && m_step == 3 && m_kind >= 2 && m_npend) begin
            m_kind = 1;
            clr    = 1;
          end
          m_step++;
        end
      end
      if (rise)     m_npend = 1;
      else if (clr) m_npend = 0;
      m_done = fin;
    end
  endtask

  task automatic check_outputs();
    int         ph;
    logic [7:0] pbyte, lo, tbl;
    logic [7:0] exp_sel, got_sel;
    ph = (m_step == 0) ? 0 : ((m_len == 4) ? m_step + 3 : m_step);
    lo = (m_kind == 0) ? 8'hFC : (m_kind == 1) ? 8'hFA : 8'hFE;
    case (ph)
      1, 2, 3: pbyte = 8'h01;
      5:       pbyte = lo;
      7:       pbyte = lo + 8'h01;
      default: pbyte = 8'hFF;
    endcase
    exp_sel = '0;
    for (int i = 0; i < 8; i++) begin
      tbl = (i == 0) ? 8'h01 : (i == 1) ? 8'h00 : 8'hF8 + 8'(i);
      exp_sel[i] = (ph != 0) && (pbyte == tbl);
    end
    got_sel = {set_FF, set_FE, set_FD, set_FC, set_FB, set_FA, set_00, set_01};
    chk("preset_sel", 32'(got_sel), 32'(exp_sel));
    chk("push_we", 32'(push_we), 32'(ph >= 1 && ph <= 3));
    if (ph >= 1 && ph <= 3)
      chk("push_sel", 32'(push_sel), 32'(ph - 1));
    chk("b_flag", 32'(b_flag), 32'(ph == 3 && m_kind == 3));
    chk("vec_kind", 32'(vec_kind), 32'(m_kind));
    chk("busy", 32'(busy), 32'(m_step != 0));
    chk("done", 32'(done), 32'(m_done));
    chk("set_i", 32'(set_i), 32'(m_done));
    if (m_done)
      $display("[TB] sequence complete: vec_kind=%0d at t=%0t", m_kind, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic wait_step(input int target);
    for (int n = 0; n < 30 && m_step != target; n++)
      tick();
    chk("wait_step", 32'(m_step), 32'(target));
  endtask

  initial begin
    rst = 1; ready = 1; nmi_in = 0; irq_in = 0; brk_req = 0; i_flag = 0;
    m_step = 0; m_len = 7; m_kind = 0; m_rpend = 1; m_npend = 0; m_prev = 0; m_done = 0;
    #1;
    tick(); tick();

    // Reset sequence: FF FC FF FD, then done.
    rst = 0;
    repeat (6) tick();

    // Unmasked IRQ.
    irq_in = 1; tick(); irq_in = 0;
    repeat (8) tick();

    // Masked IRQ: stays idle.
    i_flag = 1; irq_in = 1;
    repeat (4) begin tick(); chk("masked_idle", 32'(busy), 32'd0); end
    irq_in = 0; i_flag = 0;

    // BRK beats IRQ.
    brk_req = 1; irq_in = 1; tick(); brk_req = 0; irq_in = 0;
    repeat (8) tick();

    // NMI edge during PUSH_PCL of an IRQ hijacks the vector.
    irq_in = 1; tick(); irq_in = 0;
    wait_step(2);
    nmi_in = 1;
    repeat (9) tick();
    nmi_in = 0;
    repeat (3) tick();

    // Stall three cycles in VLO_ADL of an NMI sequence.
    nmi_in = 1;
    wait_step(5);
    ready = 0;
    repeat (3) begin tick(); chk("stall_FA", 32'(set_FA), 32'd1); end
    ready = 1;
    nmi_in = 0;

    // Reset asserted in VHI_ADH discards the sequence and reruns reset.
    wait_step(6);
    rst = 1; tick(); chk("rst_mid_busy", 32'(busy), 32'd0);
    rst = 0;
    repeat (7) tick();

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      ready   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) nmi_in = ~nmi_in;
      if ($urandom_range(0, 7) == 0)  irq_in = ~irq_in;
      if ($urandom_range(0, 31) == 0) i_flag = ~i_flag;
      brk_req = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
